// File: rtl/moving_average_filter.sv
// N-tap boxcar average over a circular sample window, running-sum form.
// Two CE-qualified stages: accumulate, then round/shift to the output register.
module moving_average_filter #(
  parameter int DATA_W    = 8,
  parameter int LOG2_TAPS = 3,
  parameter int ROUND     = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_ce,
  input  logic                     i_clear,
  input  logic signed [DATA_W-1:0] data_in,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     o_ce,
  output logic                     o_full
);

  localparam int unsigned N     = 1 << LOG2_TAPS;
  localparam int          ACC_W = DATA_W + LOG2_TAPS;
  localparam int          RND   = (ROUND != 0) ? (1 << (LOG2_TAPS - 1)) : 0;
  localparam logic [LOG2_TAPS:0] FILL_MAX = (LOG2_TAPS + 1)'(N);

  logic signed [DATA_W-1:0] r_win [N];
  logic [LOG2_TAPS-1:0]     r_wr_ptr;
  logic signed [ACC_W-1:0]  r_acc;
  logic [LOG2_TAPS:0]       r_fill_cnt;
  logic                     r_sum_ce;
  logic                     r_full;
  logic                     r_o_ce;
  logic signed [DATA_W-1:0] r_data_out;

  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [ACC_W:0]    w_rnd_sum;
  logic [LOG2_TAPS:0]       w_fill_next;

  always_comb begin
    w_acc_next  = r_acc + ACC_W'(data_in) - ACC_W'(r_win[r_wr_ptr]);
    // One guard bit above the accumulator so the rounding add cannot overflow
    w_rnd_sum   = (ACC_W + 1)'(r_acc) + (ACC_W + 1)'(RND);
    w_fill_next = (r_fill_cnt == FILL_MAX) ? r_fill_cnt
                                           : r_fill_cnt + (LOG2_TAPS + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc      <= '0;
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_full     <= 1'b0;
      r_sum_ce   <= 1'b0;
      r_o_ce     <= 1'b0;
      r_data_out <= '0;
      for (int unsigned i = 0; i < N; i++) r_win[i] <= '0;
    end else begin
      r_sum_ce <= 1'b0;
      if (i_clear) begin
        r_acc      <= '0;
        r_wr_ptr   <= '0;
        r_fill_cnt <= '0;
        r_full     <= 1'b0;
        for (int unsigned i = 0; i < N; i++) r_win[i] <= '0;
      end else if (i_ce) begin
        r_acc           <= w_acc_next;
        r_win[r_wr_ptr] <= data_in;
        r_wr_ptr        <= r_wr_ptr + LOG2_TAPS'(1);
        r_fill_cnt      <= w_fill_next;
        r_full          <= (w_fill_next == FILL_MAX);
        r_sum_ce        <= 1'b1;
      end
      // Stage 1 still drains a sum already in flight when a clear arrives
      r_o_ce <= r_sum_ce;
      if (r_sum_ce) r_data_out <= DATA_W'(w_rnd_sum >>> LOG2_TAPS);
    end
  end

  assign data_out = r_data_out;
  assign o_ce     = r_o_ce;
  assign o_full   = r_full;

endmodule

// File: tb/tb_moving_average_filter.sv
// Directed table and hand sequences on the 8-bit/8-tap filter, plus a
// gapped random run of four parameterisations against a direct-sum model.
module tb_moving_average_filter;

  logic clk = 1'b0, reset_n = 1'b0, i_ce = 1'b0, i_clear = 1'b0;
  logic signed [7:0]  data_in = '0, d_a = '0;
  logic signed [15:0] d_b = '0;
  logic signed [7:0]  dout_m, dout_t, dout_a;
  logic signed [15:0] dout_b;
  logic oce_m, oce_t, oce_a, oce_b, full_m, full_t, full_a, full_b;

  always #5 clk = ~clk;

  moving_average_filter #(.DATA_W(8), .LOG2_TAPS(3), .ROUND(1)) dut_m (
    .clk(clk), .reset_n(reset_n), .i_ce(i_ce), .i_clear(i_clear), .data_in(data_in),
    .data_out(dout_m), .o_ce(oce_m), .o_full(full_m));
  moving_average_filter #(.DATA_W(8), .LOG2_TAPS(3), .ROUND(0)) dut_t (
    .clk(clk), .reset_n(reset_n), .i_ce(i_ce), .i_clear(i_clear), .data_in(data_in),
    .data_out(dout_t), .o_ce(oce_t), .o_full(full_t));
  moving_average_filter #(.DATA_W(8), .LOG2_TAPS(1), .ROUND(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .i_ce(i_ce), .i_clear(i_clear), .data_in(d_a),
    .data_out(dout_a), .o_ce(oce_a), .o_full(full_a));
  moving_average_filter #(.DATA_W(16), .LOG2_TAPS(6), .ROUND(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .i_ce(i_ce), .i_clear(i_clear), .data_in(d_b),
    .data_out(dout_b), .o_ce(oce_b), .o_full(full_b));

  int nerr = 0, nchk = 0;
  bit mchk = 1'b0;

  // Reference model: keeps the raw window and sums it directly every sample
  int ml [4] = '{3, 3, 1, 6};
  int mr [4] = '{1, 0, 1, 1};
  int mw [4] = '{8, 8, 8, 16};
  longint hist [4][64];
  int unsigned hp [4], cnt [4];
  bit mv [4], eoce [4], efull [4];
  longint mval [4], eout [4];

  function automatic longint sample_of(int d);
    case (d)
      0, 1:    return longint'(data_in);
      2:       return longint'(d_a);
      default: return longint'(d_b);
    endcase
  endfunction

  function automatic longint get_out(int d);
    case (d)
      0: return longint'(dout_m);
      1: return longint'(dout_t);
      2: return longint'(dout_a);
      default: return longint'(dout_b);
    endcase
  endfunction

  function automatic longint get_oce(int d);
    case (d)
      0: return longint'(oce_m);
      1: return longint'(oce_t);
      2: return longint'(oce_a);
      default: return longint'(oce_b);
    endcase
  endfunction

  function automatic longint get_full(int d);
    case (d)
      0: return longint'(full_m);
      1: return longint'(full_t);
      2: return longint'(full_a);
      default: return longint'(full_b);
    endcase
  endfunction

  function automatic void model_update();
    for (int d = 0; d < 4; d++) begin
      int unsigned n;
      longint sum, t;
      n = 1 << ml[d];
      if (!reset_n) begin
        for (int k = 0; k < 64; k++) hist[d][k] = 0;
        hp[d] = 0; cnt[d] = 0; mv[d] = 0; eoce[d] = 0; efull[d] = 0; eout[d] = 0; mval[d] = 0;
      end else begin
        eoce[d] = mv[d];
        if (mv[d]) eout[d] = mval[d];
        mv[d] = 0;
        if (i_clear) begin
          for (int k = 0; k < 64; k++) hist[d][k] = 0;
          hp[d] = 0; cnt[d] = 0; efull[d] = 0;
        end else if (i_ce) begin
          hist[d][hp[d]] = sample_of(d);
          hp[d] = (hp[d] + 1) % n;
          if (cnt[d] < n) cnt[d]++;
          efull[d] = (cnt[d] >= n);
          sum = 0;
          for (int unsigned k = 0; k < n; k++) sum += hist[d][k];
          t = (sum + ((mr[d] != 0) ? (longint'(1) << (ml[d] - 1)) : 0)) >>> ml[d];
          t = t & ((longint'(1) << mw[d]) - 1);
          if (t >= (longint'(1) << (mw[d] - 1))) t -= (longint'(1) << mw[d]);
          mval[d] = t;
          mv[d] = 1;
        end
      end
    end
  endfunction

  function automatic void chk(string nm, longint act, longint exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  task automatic cyc(input bit ce, input bit clr, input longint d);
    i_ce = ce; i_clear = clr; data_in = 8'(d);
    d_a = 8'($urandom); d_b = 16'($urandom);
    @(posedge clk);
    model_update();
    #1;
    if (mchk)
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("model%0d_oce", k), get_oce(k), longint'(eoce[k]));
        chk($sformatf("model%0d_dout", k), get_out(k), eout[k]);
        chk($sformatf("model%0d_full", k), get_full(k), longint'(efull[k]));
      end
  endtask

  typedef struct {
    bit ce;
    logic signed [7:0] din;
    bit oce;
    logic signed [7:0] dout_m;
    logic signed [7:0] dout_t;
    bit full;
  } vec_t;

  vec_t tbl [12];

  initial begin
    // Step of 100: rounded and truncated averages, output one cycle after stage 0
    tbl[0]  = '{1, 100, 0,   0,   0, 0};
    tbl[1]  = '{1, 100, 1,  13,  12, 0};
    tbl[2]  = '{1, 100, 1,  25,  25, 0};
    tbl[3]  = '{1, 100, 1,  38,  37, 0};
    tbl[4]  = '{1, 100, 1,  50,  50, 0};
    tbl[5]  = '{1, 100, 1,  63,  62, 0};
    tbl[6]  = '{1, 100, 1,  75,  75, 0};
    tbl[7]  = '{1, 100, 1,  88,  87, 1};
    tbl[8]  = '{1, 100, 1, 100, 100, 1};
    tbl[9]  = '{1, 100, 1, 100, 100, 1};
    tbl[10] = '{0,   0, 1, 100, 100, 1};
    tbl[11] = '{0,   0, 0, 100, 100, 1};

    reset_n = 1'b0;
    repeat (3) cyc(0, 0, 0);
    chk("reset_dout", longint'(dout_m), 0);
    chk("reset_oce", longint'(oce_m), 0);
    chk("reset_full", longint'(full_m), 0);
    reset_n = 1'b1;

    for (int k = 0; k < 12; k++) begin
      cyc(tbl[k].ce, 0, longint'(tbl[k].din));
      chk($sformatf("step%0d_oce", k), longint'(oce_m), longint'(tbl[k].oce));
      chk($sformatf("step%0d_dout", k), longint'(dout_m), longint'(tbl[k].dout_m));
      chk($sformatf("step%0d_dout_trunc", k), longint'(dout_t), longint'(tbl[k].dout_t));
      chk($sformatf("step%0d_full", k), longint'(full_m), longint'(tbl[k].full));
    end

    // Impulse: eight strobes of 8, then zeros
    cyc(0, 1, 0);
    chk("impulse_clear_full", longint'(full_m), 0);
    for (int j = 0; j <= 12; j++) begin
      cyc(j < 10, 0, (j == 0) ? 64 : 0);
      chk($sformatf("impulse%0d_oce", j), longint'(oce_m), (j >= 1 && j <= 10) ? 1 : 0);
      if (j >= 1)
        chk($sformatf("impulse%0d_dout", j), longint'(dout_m), (j <= 8) ? 8 : 0);
    end

    // Extremes: full-scale positive then negative, no wrap
    cyc(0, 1, 0);
    for (int j = 0; j <= 16; j++) begin
      cyc(j < 16, 0, (j < 8) ? 127 : -128);
      if (j == 8) begin
        chk("extreme_pos", longint'(dout_m), 127);
        chk("extreme_pos_trunc", longint'(dout_t), 127);
      end
      if (j == 16) begin
        chk("extreme_neg", longint'(dout_m), -128);
        chk("extreme_neg_trunc", longint'(dout_t), -128);
      end
    end

    // Rounding of a lone -4
    cyc(0, 1, 0);
    cyc(1, 0, -4);
    cyc(0, 0, 0);
    chk("round_oce", longint'(oce_m), 1);
    chk("round_half_up", longint'(dout_m), 0);
    chk("round_trunc", longint'(dout_t), -1);

    // Clear after five samples; the sample alongside the clear is dropped
    cyc(0, 1, 0);
    repeat (5) cyc(1, 0, 100);
    cyc(1, 1, 77);
    chk("clear_full", longint'(full_m), 0);
    cyc(1, 0, 40);
    chk("clear_no_oce", longint'(oce_m), 0);
    cyc(0, 0, 0);
    chk("clear_post_oce", longint'(oce_m), 1);
    chk("clear_post_dout", longint'(dout_m), 5);
    chk("clear_post_dout_trunc", longint'(dout_t), 5);
    chk("clear_post_full", longint'(full_m), 0);

    // Reset mid-stream cancels the pending strobe
    cyc(1, 0, 20);
    cyc(1, 0, 30);
    reset_n = 1'b0;
    cyc(1, 0, 40);
    chk("midreset_dout", longint'(dout_m), 0);
    chk("midreset_oce", longint'(oce_m), 0);
    chk("midreset_full", longint'(full_m), 0);
    reset_n = 1'b1;
    cyc(0, 0, 0);
    chk("midreset_pending", longint'(oce_m), 0);
    for (int j = 0; j <= 8; j++) begin
      longint exp50 [8] = '{6, 13, 19, 25, 31, 38, 44, 50};
      cyc(j < 8, 0, 50);
      if (j >= 1) chk($sformatf("ramp50_%0d", j), longint'(dout_m), exp50[j-1]);
      chk($sformatf("ramp50_full%0d", j), longint'(full_m), (j >= 7) ? 1 : 0);
    end

    // Gapped random stream, all four parameterisations against the model
    mchk = 1'b1;
    for (int i = 0; i < 200; i++) begin
      int gap;
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) cyc(0, 0, 0);
      cyc(1, ($urandom_range(0, 39) == 0), longint'($urandom_range(0, 255)) - 128);
    end
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    mchk = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
